// File: rtl/uart_rx_cmd_ctrl.sv
// Six-byte command-frame sequencer behind uart_rx: HDR CMD ADDR DATA_H DATA_L SUM.
// Optional inter-byte timeout resync is built only when UART_RX_CMD_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | hunting for C_HEADER, other bytes dropped silently
// ST_CMD  | expecting command byte, running sum just cleared
// ST_ADDR | expecting register address byte
// ST_DATH | expecting data high byte
// ST_DATL | expecting data low byte
// ST_SUM  | expecting checksum byte, result issued next cycle
module uart_rx_cmd_ctrl #(
  parameter logic [7:0]  C_HEADER = 8'hA5,
  parameter logic [19:0] C_TO_CNT = 20'd34720
) (
  input  logic        CLK_100M,
  input  logic        IO_RESET,
  input  logic [7:0]  UART_RX_DATA,
  input  logic        UART_RX_COMPLETE,
  output logic        REG_WR_EN,
  output logic        REG_RD_REQ,
  output logic [7:0]  REG_ADDR,
  output logic [15:0] REG_WDATA,
  output logic        FRAME_ERR,
  output logic [1:0]  ERR_CODE,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATH,
    ST_DATL,
    ST_SUM
  } state_t;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dath_q, dath_d;
  logic [7:0]  datl_q, datl_d;
  logic [7:0]  sum_q, sum_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_req_q, rd_req_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        to_hit;

`ifdef UART_RX_CMD_TIMEOUT_EN
  logic [19:0] to_cnt_q, to_cnt_d;

  // Saturating counter of silent cycles while a frame is open.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (UART_RX_COMPLETE || (state_q == ST_IDLE)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != C_TO_CNT) begin
      to_cnt_d = to_cnt_q + 20'd1;
    end
  end

  always_ff @(posedge CLK_100M or posedge IO_RESET) begin
    if (IO_RESET) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_hit = (to_cnt_q == C_TO_CNT) && (state_q != ST_IDLE);
`else
  logic unused_to_cnt;
  assign unused_to_cnt = ^C_TO_CNT;
  assign to_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    dath_d      = dath_q;
    datl_d      = datl_q;
    sum_d       = sum_q;
    wr_en_d     = 1'b0;
    rd_req_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    // A byte on the terminal-count cycle takes precedence over the timeout.
    if (UART_RX_COMPLETE) begin
      unique case (state_q)
        ST_IDLE: begin
          if (UART_RX_DATA == C_HEADER) begin
            state_d = ST_CMD;
            sum_d   = '0;
          end
        end
        ST_CMD: begin
          cmd_d   = UART_RX_DATA;
          sum_d   = sum_q + UART_RX_DATA;
          state_d = ST_ADDR;
        end
        ST_ADDR: begin
          addr_d  = UART_RX_DATA;
          sum_d   = sum_q + UART_RX_DATA;
          state_d = ST_DATH;
        end
        ST_DATH: begin
          dath_d  = UART_RX_DATA;
          sum_d   = sum_q + UART_RX_DATA;
          state_d = ST_DATL;
        end
        ST_DATL: begin
          datl_d  = UART_RX_DATA;
          sum_d   = sum_q + UART_RX_DATA;
          state_d = ST_SUM;
        end
        ST_SUM: begin
          state_d = ST_IDLE;
          if (UART_RX_DATA != sum_q) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b01;
          end else if (cmd_q == CMD_WR) begin
            wr_en_d     = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = {dath_q, datl_q};
          end else if (cmd_q == CMD_RD) begin
            rd_req_d    = 1'b1;
            reg_addr_d  = addr_q;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (to_hit) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = 2'b11;
    end
  end

  always_ff @(posedge CLK_100M or posedge IO_RESET) begin
    if (IO_RESET) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      dath_q      <= '0;
      datl_q      <= '0;
      sum_q       <= '0;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      dath_q      <= dath_d;
      datl_q      <= datl_d;
      sum_q       <= sum_d;
      wr_en_q     <= wr_en_d;
      rd_req_q    <= rd_req_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign REG_WR_EN  = wr_en_q;
  assign REG_RD_REQ = rd_req_q;
  assign REG_ADDR   = reg_addr_q;
  assign REG_WDATA  = reg_wdata_q;
  assign FRAME_ERR  = frame_err_q;
  assign ERR_CODE   = err_code_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: frame-level reference model, vector table, hand sequences, random frames.
module tb_uart_rx_cmd_ctrl;

  localparam int TO = 100;
`ifdef UART_RX_CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_complete;
  logic        wr_en, rd_req, frame_err, busy;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [1:0]  err_code;

  uart_rx_cmd_ctrl #(.C_HEADER(8'hA5), .C_TO_CNT(20'd100)) dut (
    .CLK_100M(clk),
    .IO_RESET(rst),
    .UART_RX_DATA(rx_data),
    .UART_RX_COMPLETE(rx_complete),
    .REG_WR_EN(wr_en),
    .REG_RD_REQ(rd_req),
    .REG_ADDR(reg_addr),
    .REG_WDATA(reg_wdata),
    .FRAME_ERR(frame_err),
    .ERR_CODE(err_code),
    .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: collects bytes after a header, judges the frame once five follow.
  logic [7:0]  fq[$];
  bit          m_in_frame;
  int          m_gap;
  bit          m_wr, m_rd, m_err;
  logic [1:0]  m_code;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;

  task automatic model_reset();
    fq.delete();
    m_in_frame = 0; m_gap = 0;
    m_wr = 0; m_rd = 0; m_err = 0;
    m_code = 0; m_addr = 0; m_wdata = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    int s;
    m_wr = 0; m_rd = 0; m_err = 0;
    if (v) begin
      m_gap = 0;
      if (!m_in_frame) begin
        if (d == 8'hA5) begin
          m_in_frame = 1;
          fq.delete();
        end
      end else begin
        fq.push_back(d);
        if (fq.size() == 5) begin
          s = (int'(fq[0]) + int'(fq[1]) + int'(fq[2]) + int'(fq[3])) % 256;
          if (s != int'(fq[4])) begin
            m_err = 1; m_code = 2'b01;
          end else if (fq[0] == 8'h01) begin
            m_wr = 1; m_addr = fq[1]; m_wdata = {fq[2], fq[3]};
          end else if (fq[0] == 8'h02) begin
            m_rd = 1; m_addr = fq[1];
          end else begin
            m_err = 1; m_code = 2'b10;
          end
          m_in_frame = 0;
        end
      end
    end else if (m_in_frame) begin
      m_gap++;
      if (TO_EN && m_gap == TO + 1) begin
        m_in_frame = 0;
        m_err = 1; m_code = 2'b11;
      end
    end
  endtask

  task automatic check_model();
    chk("wr_en", 32'(wr_en), 32'(m_wr));
    chk("rd_req", 32'(rd_req), 32'(m_rd));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("reg_addr", 32'(reg_addr), 32'(m_addr));
    chk("reg_wdata", 32'(reg_wdata), 32'(m_wdata));
    chk("busy", 32'(busy), 32'(m_in_frame));
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    rx_complete = v;
    rx_data     = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    rx_complete = 1'b0;
    rx_data     = 8'($urandom);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 5; i >= 0; i--) step(1'b1, f[i*8 +: 8]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr"}, 32'(wr_en), 0);
    chk({tag, "_rd"}, 32'(rd_req), 0);
    chk({tag, "_addr"}, 32'(reg_addr), 0);
    chk({tag, "_wdata"}, 32'(reg_wdata), 0);
    chk({tag, "_err"}, 32'(frame_err), 0);
    chk({tag, "_code"}, 32'(err_code), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  typedef struct {
    logic [47:0] frame;
    bit          wr, rd, err;
    logic [1:0]  code;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [47:0] f;
    logic [7:0]  cmd, ad, dh, dl, sm;
    int          n;

    vecs[0] = '{48'hA5_01_10_12_34_57, 1, 0, 0, 2'b00, 8'h10, 16'h1234};
    vecs[1] = '{48'hA5_02_20_00_00_22, 0, 1, 0, 2'b00, 8'h20, 16'h1234};
    vecs[2] = '{48'hA5_01_10_12_34_58, 0, 0, 1, 2'b01, 8'h20, 16'h1234};
    vecs[3] = '{48'hA5_03_10_00_00_13, 0, 0, 1, 2'b10, 8'h20, 16'h1234};
    vecs[4] = '{48'hA5_01_11_00_01_13, 1, 0, 0, 2'b10, 8'h11, 16'h0001};
    vecs[5] = '{48'hA5_01_A5_00_01_A7, 1, 0, 0, 2'b10, 8'hA5, 16'h0001};
    vecs[6] = '{48'hA5_01_FF_FF_FF_FE, 1, 0, 0, 2'b10, 8'hFF, 16'hFFFF};
    vecs[7] = '{48'hA5_02_30_AB_CD_AA, 0, 1, 0, 2'b10, 8'h30, 16'hFFFF};
    vecs[8] = '{48'hA5_07_00_00_00_00, 0, 0, 1, 2'b01, 8'h30, 16'hFFFF};

    rst = 1'b1; rx_complete = 1'b0; rx_data = 8'h00;
    model_reset();
    #23;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Garbage before a header is ignored.
    step(1'b1, 8'h00); step(1'b1, 8'hFF); step(1'b1, 8'h5A);
    chk("garbage_busy", 32'(busy), 0);
    chk("garbage_err", 32'(frame_err), 0);

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].frame);
      chk($sformatf("v%0d_wr", i), 32'(wr_en), 32'(vecs[i].wr));
      chk($sformatf("v%0d_rd", i), 32'(rd_req), 32'(vecs[i].rd));
      chk($sformatf("v%0d_err", i), 32'(frame_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_code", i), 32'(err_code), 32'(vecs[i].code));
      chk($sformatf("v%0d_addr", i), 32'(reg_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_wdata", i), 32'(reg_wdata), 32'(vecs[i].wdata));
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
      if (i[0]) idle(2);
    end
    idle(1);
    chk("strobe_one_cycle", 32'({wr_en, rd_req, frame_err}), 0);

`ifdef UART_RX_CMD_TIMEOUT_EN
    step(1'b1, 8'hA5); step(1'b1, 8'h01);
    idle(TO);
    chk("to_pre_err", 32'(frame_err), 0);
    chk("to_pre_busy", 32'(busy), 1);
    idle(1);
    chk("to_err", 32'(frame_err), 1);
    chk("to_code", 32'(err_code), 32'(2'b11));
    chk("to_busy", 32'(busy), 0);
    idle(1);
    chk("to_err_pulse", 32'(frame_err), 0);
    chk("to_code_hold", 32'(err_code), 32'(2'b11));
    send_frame(48'hA5_01_10_12_34_57);
    chk("to_after_wr", 32'(wr_en), 1);
    chk("to_after_addr", 32'(reg_addr), 32'h10);

    step(1'b1, 8'hA5); step(1'b1, 8'h01);
    idle(TO);
    step(1'b1, 8'h10);
    chk("tc_byte_err", 32'(frame_err), 0);
    chk("tc_byte_busy", 32'(busy), 1);
    step(1'b1, 8'h12); step(1'b1, 8'h34); step(1'b1, 8'h57);
    chk("tc_wr", 32'(wr_en), 1);
    chk("tc_wdata", 32'(reg_wdata), 32'h1234);
`else
    step(1'b1, 8'hA5); step(1'b1, 8'h01);
    idle(3 * TO);
    chk("nto_busy", 32'(busy), 1);
    chk("nto_err", 32'(frame_err), 0);
    step(1'b1, 8'h10); step(1'b1, 8'h12); step(1'b1, 8'h34); step(1'b1, 8'h57);
    chk("nto_wr", 32'(wr_en), 1);
    chk("nto_wdata", 32'(reg_wdata), 32'h1234);
`endif

    // Reset in the middle of a frame.
    step(1'b1, 8'hA5); step(1'b1, 8'h01); step(1'b1, 8'h10);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    send_frame(48'hA5_01_10_12_34_57);
    chk("postrst_wr", 32'(wr_en), 1);
    chk("postrst_addr", 32'(reg_addr), 32'h10);
    chk("postrst_wdata", 32'(reg_wdata), 32'h1234);

    // Random frames with corruption and gaps around the timeout boundary.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 5) == 0) step(1'b1, 8'($urandom));
      n   = int'($urandom_range(0, 9));
      cmd = (n < 4) ? 8'h01 : (n < 8) ? 8'h02 : 8'($urandom);
      ad  = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
      sm  = cmd + ad + dh + dl;
      if ($urandom_range(0, 4) == 0) sm = sm + 8'($urandom_range(1, 255));
      f = {8'hA5, cmd, ad, dh, dl, sm};
      for (int i = 5; i >= 0; i--) begin
        step(1'b1, f[i*8 +: 8]);
        if (i != 0) begin
          if ($urandom_range(0, 40) == 0) idle(int'($urandom_range(TO - 1, TO + 2)));
          else idle(int'($urandom_range(0, 3)));
        end
      end
      idle(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
